// File: rtl/pair_triple_pattern_gen.sv
// pair_triple_pattern_gen
// Stimulus source for the pair/triple detector. It streams (a,b) operand pairs
// over a val/rdy handshake, and each pair carries the detector's expected output.
// The exhaustive and popcount-filtered modes walk a 6-bit index in ascending order.
// Optional feature macro: PAIR_TRIPLE_GEN_LFSR_EN. When it is defined, mode 2'b11
// emits num LFSR patterns. When it is not defined, mode 2'b11 behaves as mode 2'b00.
module pair_triple_pattern_gen #(
    parameter logic [5:0] SEED  = 6'h2D,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [2:0]       out_a,
    output logic [2:0]       out_b,
    output logic             out_exp,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0] IDX_LAST = 6'd63;

    // Popcount of a 3-bit operand. The sum fits in 2 bits because its maximum is 3.
    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // This is the detector's reference result. At least one operand has two or more bits set.
    function automatic logic multi_ones(input logic [2:0] a, input logic [2:0] b);
        return (popcnt3(a) >= 2'd2) || (popcnt3(b) >= 2'd2);
    endfunction

    // Filter used by the scanning modes.
    // Mode 2'b11 falls into the default branch, so it is treated as exhaustive.
    function automatic logic scan_match(input logic [1:0] m, input logic [2:0] a,
                                        input logic [2:0] b);
        logic hit;
        case (m)
            2'b01:   hit = !multi_ones(a, b);
            2'b10:   hit = multi_ones(a, b);
            default: hit = 1'b1;
        endcase
        return hit;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [5:0] idx_q, idx_d;
    logic       out_val_q, out_val_d;
    logic [2:0] out_a_q, out_a_d;
    logic [2:0] out_b_q, out_b_d;
    logic       out_exp_q, out_exp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rand_mode_s;

`ifdef PAIR_TRIPLE_GEN_LFSR_EN
    // An all-zero seed would lock the LFSR, so a seed of zero is replaced by 1.
    localparam logic [5:0] SEED_EFF = (SEED == 6'd0) ? 6'h01 : SEED;

    logic [5:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // x^6+x^5+1 Fibonacci LFSR, shifting toward the MSB.
    function automatic logic [5:0] lfsr_step(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    // Random mode is active only when the LFSR is built in.
    always_comb begin
        rand_mode_s = (mode_q == 2'b11);
    end
`else
    // Without the LFSR, num and SEED have no effect. Folding them here marks them as intentionally unused.
    logic unused_cfg_s;

    // Random mode does not exist in this build.
    always_comb begin
        rand_mode_s  = 1'b0;
        unused_cfg_s = ^{num, SEED};
    end
`endif

    // Next-state logic and next values for the registered outputs.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_exp_d = out_exp_q;
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    idx_d   = 6'd0;
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
                    cnt_d   = num;
`endif
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rand_mode_s) begin
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        out_a_d   = lfsr_q[5:3];
                        out_b_d   = lfsr_q[2:0];
                        out_exp_d = multi_ones(lfsr_q[5:3], lfsr_q[2:0]);
                        state_d   = ST_EMIT;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else if (scan_match(mode_q, idx_q[5:3], idx_q[2:0])) begin
                    out_a_d   = idx_q[5:3];
                    out_b_d   = idx_q[2:0];
                    out_exp_d = multi_ones(idx_q[5:3], idx_q[2:0]);
                    state_d   = ST_EMIT;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_EMIT: begin
                // out_val is always high here, so out_rdy alone completes the transfer.
                if (!out_rdy) begin
                    state_d = ST_EMIT;
                end else if (rand_mode_s) begin
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
                    lfsr_d  = lfsr_step(lfsr_q);
                    cnt_d   = cnt_q - CNT_W'(1);
`endif
                    state_d = ST_SCAN;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_val_d = (state_d == ST_EMIT);
        busy_d    = (state_d == ST_SCAN) || (state_d == ST_EMIT);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers. Reset aborts a run immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= 2'b00;
            idx_q     <= 6'd0;
            out_val_q <= 1'b0;
            out_a_q   <= 3'd0;
            out_b_q   <= 3'd0;
            out_exp_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            out_val_q <= out_val_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            out_exp_q <= out_exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef PAIR_TRIPLE_GEN_LFSR_EN
    // The LFSR state persists across runs. Only reset reloads the seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    assign out_val = out_val_q;
    assign out_a   = out_a_q;
    assign out_b   = out_b_q;
    assign out_exp = out_exp_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// Testbench for pair_triple_pattern_gen.
// The reference model builds each run's expected pattern list directly from the
// index and popcount rules, and from the LFSR recurrence when
// PAIR_TRIPLE_GEN_LFSR_EN is defined.
module tb_pair_triple_pattern_gen;

    localparam int         CNT_W = 8;
    localparam logic [5:0] SEED  = 6'h2D;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num;
    logic             out_val;
    logic             out_rdy;
    logic [2:0]       out_a;
    logic [2:0]       out_b;
    logic             out_exp;
    logic             busy;
    logic             done;

    pair_triple_pattern_gen #(.SEED(SEED), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num(num),
        .out_val(out_val), .out_rdy(out_rdy), .out_a(out_a), .out_b(out_b),
        .out_exp(out_exp), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [6:0] exp_q[$];
    int         m_lfsr;

    task automatic check_eq(input string tag, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic int ones3(input int v);
        return (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
    endfunction

    function automatic int lfsr_next(input int v);
        return ((v << 1) & 63) | (((v >> 5) ^ (v >> 4)) & 1);
    endfunction

    function automatic logic [6:0] make_pat(input int a, input int b);
        int e;
        e = (ones3(a) > 1 || ones3(b) > 1) ? 1 : 0;
        return 7'((a << 4) | (b << 1) | e);
    endfunction

    // Build the expected pattern list for one run into exp_q.
    task automatic build_expected(input logic [1:0] m, input int n);
        int  ca, cb, v;
        bit  keep;
        exp_q.delete();
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
        if (m == 2'b11) begin
            v = m_lfsr;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(make_pat(v >> 3, v & 7));
                v = lfsr_next(v);
            end
            return;
        end
`endif
        v = n;
        for (int i = 0; i < 64; i++) begin
            ca = ones3(i / 8);
            cb = ones3(i % 8);
            if (m == 2'b01)      keep = (ca <= 1) && (cb <= 1);
            else if (m == 2'b10) keep = (ca >= 2) || (cb >= 2);
            else                 keep = 1'b1;
            if (keep) exp_q.push_back(make_pat(i / 8, i % 8));
        end
    endtask

    // Run one generation.
    // policy: 0 = always ready, 1 = random ready plus stray starts, 2 = stall 3 cycles at (000,010).
    // If abort_after is greater than 0, reset is pulsed after that many transfers.
    task automatic run(input logic [1:0] m, input int n, input int policy, input int abort_after,
                       input string name);
        int         xfers = 0, dones = 0, first_val = -1, first_x = -1, last_x = -1;
        int         ones = 0, want_ones = 0, stall = 0, exp_first;
        bit         finished = 0, prev_hold = 0, rdy, is_rand;
        logic [6:0] o, prev_o;
        build_expected(m, n);
        is_rand = 1'b0;
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
        is_rand = (m == 2'b11);
`endif
        @(negedge clk);
        start = 1'b1; mode = m; num = CNT_W'(n); out_rdy = 1'b0;
        for (int it = 0; it < 3000 && !finished; it++) begin
            @(negedge clk);
            o = {out_a, out_b, out_exp};
            if (it == 0) begin
                check_eq({name, "_busy0"}, 32'(busy), 1);
                check_eq({name, "_val0"}, 32'(out_val), 0);
            end
            if (prev_hold) begin
                check_eq({name, "_hold_val"}, 32'(out_val), 1);
                check_eq({name, "_hold_pat"}, 32'(o), 32'(prev_o));
            end
            if (out_val && first_val < 0) first_val = it;
            if (done) begin
                dones++;
                finished = 1'b1;
                check_eq({name, "_val_at_done"}, 32'(out_val), 0);
            end
            case (policy)
                1: rdy = ($urandom_range(0, 1) == 1);
                2: begin
                    if (out_val && o[6:1] == 6'b000010 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            if (out_val && rdy) begin
                if (xfers < exp_q.size())
                    check_eq($sformatf("%s_pat%0d", name, xfers), 32'(o), 32'(exp_q[xfers]));
                else
                    check_eq({name, "_extra_xfer"}, xfers + 1, exp_q.size());
                if (first_x < 0) first_x = it;
                last_x = it;
                ones += out_exp;
                xfers++;
            end
            prev_hold = out_val && !rdy;
            prev_o    = o;
            out_rdy   = rdy;
            if (policy == 1 && !finished) begin
                start = ($urandom_range(0, 3) == 0);
                mode  = 2'($urandom);
                num   = CNT_W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (abort_after > 0 && xfers == abort_after) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                check_eq({name, "_abort_val"}, 32'(out_val), 0);
                check_eq({name, "_abort_busy"}, 32'(busy), 0);
                check_eq({name, "_abort_done"}, 32'(done), 0);
                check_eq({name, "_abort_outs"}, 32'({out_a, out_b, out_exp}), 0);
                @(negedge clk);
                reset  = 1'b0;
                m_lfsr = (SEED == 6'd0) ? 1 : int'(SEED);
                return;
            end
        end
        check_eq({name, "_finished"}, 32'(finished), 1);
        check_eq({name, "_done_pulses"}, dones, 1);
        check_eq({name, "_xfer_count"}, xfers, exp_q.size());
        foreach (exp_q[k]) want_ones += exp_q[k][0];
        check_eq({name, "_exp_ones"}, ones, want_ones);
        if (exp_q.size() > 0) begin
            exp_first = is_rand ? 1 : int'(exp_q[0][6:1]) + 1;
            check_eq({name, "_first_val_cycle"}, first_val, exp_first);
            if (policy == 0)
                check_eq({name, "_spacing"}, last_x - first_x, 2 * (exp_q.size() - 1));
        end
        @(negedge clk);
        check_eq({name, "_done_1cyc"}, 32'(done), 0);
        check_eq({name, "_idle_busy"}, 32'(busy), 0);
        check_eq({name, "_idle_val"}, 32'(out_val), 0);
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
        if (is_rand) for (int k = 0; k < xfers; k++) m_lfsr = lfsr_next(m_lfsr);
`endif
    endtask

    initial begin
        m_lfsr  = (SEED == 6'd0) ? 1 : int'(SEED);
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        num     = '0;
        out_rdy = 1'b0;
        #1;
        check_eq("rst_val", 32'(out_val), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_outs", 32'({out_a, out_b, out_exp}), 0);
        #13 reset = 1'b0;

        run(2'b00, 0, 0, 0, "all");
        run(2'b01, 0, 1, 0, "few");
        run(2'b10, 0, 1, 0, "many");
        run(2'b00, 0, 2, 0, "stall");
        run(2'b00, 0, 0, 10, "abort");
        run(2'b00, 0, 1, 0, "after_abort");
`ifdef PAIR_TRIPLE_GEN_LFSR_EN
        run(2'b11, 3, 0, 0, "rand3");
        run(2'b11, 0, 0, 0, "rand0");
        for (int r = 0; r < 3; r++)
            run(2'b11, $urandom_range(1, 20), 1, 0, $sformatf("randr%0d", r));
`else
        run(2'b11, 0, 0, 0, "mode11_all");
        run(2'b11, 5, 1, 0, "mode11_rdy");
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
